// File: rtl/gray_ptr_pkg.sv
// -----------------------------------------------------------------------------
// gray_ptr_pkg
// Shared definitions for the async FIFO pointer path.
//   MIN_STAGES  : shallowest synchroniser chain that is accepted
//   PTR_MAX_W   : widest pointer the conversion helpers handle
//   gray2bin()  : Gray -> binary conversion, operands zero-extended to PTR_MAX_W
//   bin2gray()  : binary -> Gray conversion, also used by the FIFO pointer logic
// Callers cast their WIDTH-bit pointer to PTR_MAX_W bits on the way in and
// truncate the result back to WIDTH on the way out. The zero upper bits do
// not change the result, so one function serves every pointer width.
// -----------------------------------------------------------------------------
package gray_ptr_pkg;

    localparam int MIN_STAGES = 2;
    localparam int PTR_MAX_W  = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sync_stage_chain.sv
// -----------------------------------------------------------------------------
// sync_stage_chain
// Plain flop chain that brings a WIDTH-bit bus into the clk domain.
// Nothing sits between the stages, so each stage has a full period to
// resolve metastability.
// Ports:
//   clk     destination clock
//   resetn  synchronous active-low reset, clears every stage
//   d_in    asynchronous input bus (expected to be Gray coded)
//   d_out   last stage, STAGES cycles behind d_in
// -----------------------------------------------------------------------------
module sync_stage_chain
    import gray_ptr_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    generate
        if (STAGES < MIN_STAGES) begin : g_bad_stages
            $error("sync_stage_chain: STAGES must be at least %0d", MIN_STAGES);
        end
    endgenerate

    logic [WIDTH-1:0] stage_reg [STAGES];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_reg[k] <= '0;
            end
        end else begin
            stage_reg[0] <= d_in;
            for (int k = 1; k < STAGES; k++) begin
                stage_reg[k] <= stage_reg[k-1];
            end
        end
    end

    assign d_out = stage_reg[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// -----------------------------------------------------------------------------
// gray_ptr_sync
// Multi-channel Gray pointer synchroniser for the async FIFO. Each channel
// passes through its own flop chain. The channel is then decoded to binary,
// and its per-cycle advance is measured. Any advance larger than MAX_STEP is
// flagged as a fault.
// Ports:
//   clk         destination-domain clock
//   resetn      synchronous active-low reset
//   gray_in     CHANNELS x WIDTH Gray pointers, channel c at [c*WIDTH +: WIDTH]
//   err_clr     per-channel clear of err_sticky
//   gray_out    synchronised Gray pointers (last chain stage)
//   bin_out     registered binary decode of gray_out
//   delta       registered (new bin - previous bin) mod 2^WIDTH
//   adv         one-cycle pulse when bin_out changed
//   step_err    one-cycle pulse when delta exceeded MAX_STEP
//   err_sticky  step_err held until err_clr
//   primed      high once the chain and decode stage have flushed after reset
// WIDTH is limited to PTR_MAX_W bits by the shared conversion helpers.
// -----------------------------------------------------------------------------
module gray_ptr_sync
    import gray_ptr_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STAGES   = 2,
    parameter int CHANNELS = 1,
    parameter int MAX_STEP = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] gray_in,
    input  logic [CHANNELS-1:0]       err_clr,
    output logic [CHANNELS*WIDTH-1:0] gray_out,
    output logic [CHANNELS*WIDTH-1:0] bin_out,
    output logic [CHANNELS*WIDTH-1:0] delta,
    output logic [CHANNELS-1:0]       adv,
    output logic [CHANNELS-1:0]       step_err,
    output logic [CHANNELS-1:0]       err_sticky,
    output logic                      primed
);

    generate
        if (STAGES < MIN_STAGES) begin : g_bad_stages
            $error("gray_ptr_sync: STAGES must be at least %0d", MIN_STAGES);
        end
        if (WIDTH < 2 || WIDTH > PTR_MAX_W) begin : g_bad_width
            $error("gray_ptr_sync: WIDTH must be in 2..%0d", PTR_MAX_W);
        end
        if (CHANNELS < 1) begin : g_bad_channels
            $error("gray_ptr_sync: CHANNELS must be at least 1");
        end
        if (MAX_STEP < 1 || MAX_STEP > (2 ** WIDTH) - 1) begin : g_bad_step
            $error("gray_ptr_sync: MAX_STEP must be in 1..2^WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_STEP_W = WIDTH'(MAX_STEP);

    // ------------------------------------------------------------------
    // Priming. After reset is released, the chain holds STAGES stale
    // zeros and bin_out holds one more. Once STAGES+1 edges have passed,
    // bin_out reflects the live source pointer. Only then is a difference
    // between consecutive values meaningful. Until that point, a nonzero
    // source pointer at reset release would look like a huge jump from
    // zero.
    // ------------------------------------------------------------------
    localparam int PRIME_W = $clog2(STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(STAGES);

    logic [PRIME_W-1:0] prime_cnt_reg;
    logic               primed_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prime_cnt_reg <= '0;
            primed_reg    <= 1'b0;
        end else if (!primed_reg) begin
            if (prime_cnt_reg == PRIME_LAST) begin
                primed_reg <= 1'b1;
            end else begin
                prime_cnt_reg <= prime_cnt_reg + 1'b1;
            end
        end
    end

    assign primed = primed_reg;

    // ------------------------------------------------------------------
    // Per-channel synchroniser, decode, delta and error tracking.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] gray_sync;
            logic [WIDTH-1:0] bin_next;
            logic [WIDTH-1:0] delta_next;
            logic             step_err_next;

            logic [WIDTH-1:0] bin_reg;
            logic [WIDTH-1:0] delta_reg;
            logic             adv_reg;
            logic             step_err_reg;
            logic             sticky_reg;

            sync_stage_chain #(
                .WIDTH  (WIDTH),
                .STAGES (STAGES)
            ) u_chain (
                .clk    (clk),
                .resetn (resetn),
                .d_in   (gray_in[gi*WIDTH +: WIDTH]),
                .d_out  (gray_sync)
            );

            // The modular subtraction makes a wrap from all-ones to zero
            // read as a step of 1. Backward motion reads as a large
            // forward step and is therefore flagged.
            always_comb begin
                bin_next      = WIDTH'(gray2bin(PTR_MAX_W'(gray_sync)));
                delta_next    = bin_next - bin_reg;
                step_err_next = primed_reg && (delta_next > MAX_STEP_W);
            end

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    bin_reg      <= '0;
                    delta_reg    <= '0;
                    adv_reg      <= 1'b0;
                    step_err_reg <= 1'b0;
                    sticky_reg   <= 1'b0;
                end else begin
                    // bin_out keeps tracking while unprimed so that it is
                    // already settled when delta checking starts.
                    bin_reg <= bin_next;
                    if (primed_reg) begin
                        delta_reg    <= delta_next;
                        adv_reg      <= (delta_next != '0);
                        step_err_reg <= step_err_next;
                    end else begin
                        delta_reg    <= '0;
                        adv_reg      <= 1'b0;
                        step_err_reg <= 1'b0;
                    end
                    // A new error in the same cycle as a clear must not be lost.
                    sticky_reg <= step_err_next | (sticky_reg & ~err_clr[gi]);
                end
            end

            assign gray_out[gi*WIDTH +: WIDTH] = gray_sync;
            assign bin_out[gi*WIDTH +: WIDTH]  = bin_reg;
            assign delta[gi*WIDTH +: WIDTH]    = delta_reg;
            assign adv[gi]                     = adv_reg;
            assign step_err[gi]                = step_err_reg;
            assign err_sticky[gi]              = sticky_reg;
        end
    endgenerate

endmodule

// File: tb/tb_gray_ptr_sync.sv
// -----------------------------------------------------------------------------
// tb_gray_ptr_sync
// Drives directed and random Gray pointer traffic into a 2-channel,
// 3-stage instance of gray_ptr_sync. Every cycle, the outputs are compared
// against a history-based model. Literal checks at key points pin the
// expected timing.
// -----------------------------------------------------------------------------
module tb_gray_ptr_sync;

    localparam int W   = 4;
    localparam int ST  = 3;
    localparam int CH  = 2;
    localparam int MS  = 1;
    localparam int MOD = 1 << W;

    logic            clk;
    logic            resetn;
    logic [CH*W-1:0] gray_in;
    logic [CH-1:0]   err_clr;
    logic [CH*W-1:0] gray_out;
    logic [CH*W-1:0] bin_out;
    logic [CH*W-1:0] delta;
    logic [CH-1:0]   adv;
    logic [CH-1:0]   step_err;
    logic [CH-1:0]   err_sticky;
    logic            primed;

    gray_ptr_sync #(
        .WIDTH    (W),
        .STAGES   (ST),
        .CHANNELS (CH),
        .MAX_STEP (MS)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .gray_in    (gray_in),
        .err_clr    (err_clr),
        .gray_out   (gray_out),
        .bin_out    (bin_out),
        .delta      (delta),
        .adv        (adv),
        .step_err   (step_err),
        .err_sticky (err_sticky),
        .primed     (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s ch%0d @%0t: got %0h expected %0h", nm, c, $time, act, exp);
        end
    endtask

    function automatic int enc(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    // Decode by searching for the binary value whose Gray code matches.
    function automatic int dec(input int g);
        for (int b = 0; b < MOD; b++) begin
            if (enc(b) == g) return b;
        end
        return -1;
    endfunction

    function automatic logic [31:0] sl(input logic [CH*W-1:0] v, input int c);
        return 32'(v[c*W +: W]);
    endfunction

    // ------------------------------------------------------------------
    // Model: hist[c][k] is the Gray value presented k edges ago (0 = this
    // edge). A reset edge empties the pipe, which is the same as filling
    // the history with zeros.
    // ------------------------------------------------------------------
    int hist [CH][ST+2];
    int m_gray [CH], m_bin [CH], m_delta [CH];
    int m_adv [CH], m_serr [CH], m_sticky [CH];
    int m_primed;
    int rel_cnt;
    bit model_live = 1'b0;

    always @(posedge clk) begin
        model_live = 1'b1;
        if (!resetn) begin
            rel_cnt  = 0;
            m_primed = 0;
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < ST + 2; k++) hist[c][k] = 0;
                m_gray[c] = 0; m_bin[c] = 0; m_delta[c] = 0;
                m_adv[c] = 0; m_serr[c] = 0; m_sticky[c] = 0;
            end
        end else begin
            bit was_primed;
            was_primed = (rel_cnt >= ST + 1);
            if (rel_cnt < 1000) rel_cnt++;
            for (int c = 0; c < CH; c++) begin
                int prev;
                int d;
                for (int k = ST + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = int'(gray_in[c*W +: W]);
                m_gray[c] = hist[c][ST-1];
                m_bin[c]  = dec(hist[c][ST]);
                prev      = dec(hist[c][ST+1]);
                d         = ((m_bin[c] - prev) % MOD + MOD) % MOD;
                m_delta[c] = was_primed ? d : 0;
                m_adv[c]   = (was_primed && d != 0) ? 1 : 0;
                m_serr[c]  = (was_primed && d > MS) ? 1 : 0;
                m_sticky[c] = (m_serr[c] != 0 || (m_sticky[c] != 0 && !err_clr[c])) ? 1 : 0;
            end
            m_primed = (rel_cnt >= ST + 1) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("primed", 0, 32'(primed), 32'(m_primed));
            for (int c = 0; c < CH; c++) begin
                chk("gray_out",   c, sl(gray_out, c), 32'(m_gray[c]));
                chk("bin_out",    c, sl(bin_out, c),  32'(m_bin[c]));
                chk("delta",      c, sl(delta, c),    32'(m_delta[c]));
                chk("adv",        c, 32'(adv[c]),        32'(m_adv[c]));
                chk("step_err",   c, 32'(step_err[c]),   32'(m_serr[c]));
                chk("err_sticky", c, 32'(err_sticky[c]), 32'(m_sticky[c]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int c, input int b);
        gray_in[c*W +: W] = W'(enc(b));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_gray"},  0, 32'(gray_out), 32'd0);
        chk({nm, "_bin"},   0, 32'(bin_out), 32'd0);
        chk({nm, "_delta"}, 0, 32'(delta), 32'd0);
        chk({nm, "_flags"}, 0, 32'({adv, step_err, err_sticky}), 32'd0);
        chk({nm, "_primed"}, 0, 32'(primed), 32'd0);
    endtask

    int cur [CH];

    initial begin
        resetn  = 1'b0;
        gray_in = {CH{4'b0110}};
        err_clr = '0;
        tick(3);
        chk_all_zero("reset");

        // Release with a nonzero source pointer (bin 4).
        resetn = 1'b1;
        tick(ST);
        chk("prime_early", 0, 32'(primed), 32'd0);
        tick(1);
        chk("prime_on", 0, 32'(primed), 32'd1);
        chk("prime_bin", 0, sl(bin_out, 0), 32'd4);
        chk("prime_adv", 0, 32'(adv), 32'd0);
        chk("prime_serr", 0, 32'(step_err), 32'd0);
        tick(2);
        chk("prime_sticky", 0, 32'(err_sticky), 32'd0);

        // Legal walk 4 -> 15 -> 0 on both channels.
        for (int b = 5; b <= 16; b++) begin
            for (int c = 0; c < CH; c++) set_ch(c, b % MOD);
            tick(1);
        end
        tick(ST + 2);
        chk("walk_sticky", 0, 32'(err_sticky), 32'd0);

        // Single step on ch1 with ch0 static.
        set_ch(1, 1);
        tick(ST);
        chk("step_gray", 1, sl(gray_out, 1), 32'd1);
        chk("step_bin_pre", 1, sl(bin_out, 1), 32'd0);
        tick(1);
        chk("step_bin", 1, sl(bin_out, 1), 32'd1);
        chk("step_delta", 1, sl(delta, 1), 32'd1);
        chk("step_adv", 1, 32'(adv[1]), 32'd1);
        chk("step_serr", 1, 32'(step_err[1]), 32'd0);
        chk("static_adv", 0, 32'(adv[0]), 32'd0);
        chk("static_delta", 0, sl(delta, 0), 32'd0);
        tick(1);
        chk("step_adv_off", 1, 32'(adv[1]), 32'd0);

        // Walk ch1 up to 15, then wrap to 0.
        for (int b = 2; b < MOD; b++) begin
            set_ch(1, b);
            tick(1);
        end
        tick(ST + 2);
        set_ch(1, 0);
        tick(ST + 1);
        chk("wrap_bin", 1, sl(bin_out, 1), 32'd0);
        chk("wrap_delta", 1, sl(delta, 1), 32'd1);
        chk("wrap_adv", 1, 32'(adv[1]), 32'd1);
        chk("wrap_serr", 1, 32'(step_err[1]), 32'd0);

        // Illegal jump 0 -> 2 on ch0.
        set_ch(0, 2);
        tick(ST + 1);
        chk("jump_delta", 0, sl(delta, 0), 32'd2);
        chk("jump_serr", 0, 32'(step_err[0]), 32'd1);
        chk("jump_sticky", 0, 32'(err_sticky[0]), 32'd1);
        tick(1);
        chk("jump_serr_off", 0, 32'(step_err[0]), 32'd0);
        chk("jump_sticky_hold", 0, 32'(err_sticky[0]), 32'd1);
        err_clr = 2'b01;
        tick(1);
        err_clr = 2'b00;
        chk("clr_sticky", 0, 32'(err_sticky[0]), 32'd0);

        // Clear in the same cycle as a new error: set wins.
        set_ch(0, 5);
        tick(ST);
        err_clr = 2'b01;
        tick(1);
        err_clr = 2'b00;
        chk("setwin_serr", 0, 32'(step_err[0]), 32'd1);
        chk("setwin_sticky", 0, 32'(err_sticky[0]), 32'd1);
        tick(1);
        chk("setwin_hold", 0, 32'(err_sticky[0]), 32'd1);
        err_clr = 2'b01;
        tick(1);
        err_clr = 2'b00;

        // Reset in the middle of an increment sequence.
        for (int b = 6; b < 10; b++) begin
            set_ch(0, b);
            tick(1);
        end
        resetn = 1'b0;
        tick(1);
        chk_all_zero("midreset");
        resetn = 1'b1;
        tick(ST + 1);
        chk("reprime_on", 0, 32'(primed), 32'd1);
        chk("reprime_serr", 0, 32'(step_err), 32'd0);
        chk("reprime_bin", 0, sl(bin_out, 0), 32'd9);

        // Random traffic, checked by the model every cycle.
        for (int c = 0; c < CH; c++) cur[c] = dec(int'(gray_in[c*W +: W]));
        repeat (3000) begin
            for (int c = 0; c < CH; c++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r >= 8)      cur[c] = (cur[c] + $urandom_range(2, MOD - 1)) % MOD;
                else if (r >= 5) cur[c] = (cur[c] + 1) % MOD;
                set_ch(c, cur[c]);
                err_clr[c] = ($urandom_range(0, 15) == 0);
            end
            resetn = ($urandom_range(0, 199) != 0);
            tick(1);
        end
        resetn  = 1'b1;
        err_clr = '0;
        tick(ST + 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_ptr_sync.md
Name: gray_ptr_sync

Overview:
Multi-channel, parametrised pointer synchroniser for the async FIFO. It brings Gray-coded pointers from a foreign clock domain into the clk domain through a configurable-depth flop chain. It then decodes each pointer to binary, reports per-cycle advance (delta), and flags illegal steps that indicate a CDC or pointer fault. It replaces the fixed 2-flop pointer synchroniser on both FIFO sides.

Parameters:
WIDTH, 4, pointer width in bits including the wrap bit (>=2)
STAGES, 2, synchroniser flop depth (>=2; elaboration error otherwise)
CHANNELS, 1, number of independent pointers synchronised in parallel (>=1)
MAX_STEP, 1, largest legal binary advance per clk cycle (1..2^WIDTH-1)

Ports:
clk  in  1  destination-domain clock
resetn  in  1  synchronous active-low reset
gray_in  in  CHANNELS*WIDTH  Gray pointers from the source domain; channel c occupies [c*WIDTH +: WIDTH]; asynchronous to clk
err_clr  in  CHANNELS  per-channel clear of err_sticky
gray_out  out  CHANNELS*WIDTH  synchronised Gray pointer (last chain stage)
bin_out  out  CHANNELS*WIDTH  registered binary decode of gray_out
delta  out  CHANNELS*WIDTH  registered (new bin - previous bin) mod 2^WIDTH
adv  out  CHANNELS  1-cycle pulse when bin_out changed
step_err  out  CHANNELS  1-cycle pulse when delta > MAX_STEP
err_sticky  out  CHANNELS  latched step_err until err_clr
primed  out  1  high once post-reset settling is complete

Behaviour:
- Reset: the following are cleared synchronously while resetn=0: all chain stages, gray_out, bin_out, delta, adv, step_err, err_sticky, primed, prime counter. Reset asserted mid-operation takes effect on the next edge regardless of state.
- Chain: stage[0] <= gray_in; stage[k] <= stage[k-1]; gray_out = stage[STAGES-1]. Latency gray_in->gray_out = STAGES cycles. No logic between stages.
- Decode: bin_d = Gray-to-binary(gray_out) (bit i = XOR of gray bits WIDTH-1..i). Each cycle: bin_out <= bin_d; delta_d = (bin_d - bin_out) mod 2^WIDTH. Latency gray_in->bin_out = STAGES+1.
- Priming: after resetn rises, a counter counts STAGES+1 cycles, then primed <= 1 and stays 1 until reset. While primed=0, bin_out still tracks, but delta, adv and step_err are forced 0. This prevents a false error from a nonzero source pointer at reset release.
- Primed operation: delta <= delta_d; adv <= (delta_d != 0); step_err <= (delta_d > MAX_STEP).
- Wrap-around: the modular subtraction makes 2^WIDTH-1 -> 0 yield delta=1, which is legal. Backward motion appears as a large delta and is flagged when it exceeds MAX_STEP.
- err_sticky[c]: set by step_err_d[c], cleared by err_clr[c]. If set and clear occur in the same cycle, set wins.
- Channels are fully independent; there is no cross-channel interaction.

Decomposition:
- Package gray_ptr_pkg contains:
  - function gray2bin (parametrised width)
  - function bin2gray, shared with the FIFO pointer logic
  - localparam MIN_STAGES=2
- Sub-module sync_stage_chain (parameters WIDTH, STAGES; ports clk, resetn, d_in, d_out) is instantiated once per channel in a generate loop. Decode, delta, error and prime logic live in the top.

Test Plan:
- Reset: hold resetn=0 with gray_in=4'b0110 -> all outputs 0. Release -> primed=1 exactly 3 cycles later (STAGES=2); bin_out=4 with no adv or step_err pulse.
- Single step: primed, gray_in 0000->0001 at cycle t -> gray_out=0001 at t+2, bin_out=1 and delta=1 at t+3, adv pulse at t+3 only, step_err=0.
- Wrap: step gray 1000 (bin 15) -> 0000 -> bin_out 0, delta=1, adv=1, no error.
- Illegal jump: gray 0000->0011 (bin 2), MAX_STEP=1 -> delta=2, step_err 1-cycle pulse, err_sticky=1 held. Pulse err_clr alone -> sticky 0 next cycle. Pulse err_clr in the same cycle as a new error -> sticky stays 1.
- Multi-channel/depth: STAGES=3, CHANNELS=2, step ch1 0->1 while ch0 is static -> ch1 bin_out updates after 4 cycles, ch0 shows no adv, delta=0.
- Reset mid-stream: assert resetn=0 during an increment sequence -> all outputs 0 next edge. After release, priming repeats with no step_err.
